fir_decim_out: RTL
==================

Name: fir_decim_out

Overview:
- Output stage directly downstream of the 4-tap FIR filter.
- Consumes the filter's 16-bit unsigned sample stream.
- Decimates by DECIM using accumulate-and-dump, then scales by 2^-SHIFT with round-half-up and saturates to 8 bits.
- Buffers results in a DEPTH-entry FIFO behind a valid/ready output handshake, with a sticky overflow flag.

Parameters:
- DECIM, 4, decimation factor; legal range 2..16.
- SHIFT, 4, right-shift applied to the block sum; legal range 1..8.
- DEPTH, 4, FIFO entries; power of 2, range 2..16.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  in_data carries a sample this cycle
- in_data  in  16  unsigned filter output sample
- out_valid  out  1  FIFO head is valid
- out_ready  in  1  consumer accepts head this cycle
- out_data  out  8  unsigned decimated sample (FIFO head)
- fill  out  $clog2(DEPTH)+1  current FIFO occupancy
- overflow  out  1  sticky: a result was dropped because the FIFO was full
- clr_ovf  in  1  synchronous clear of overflow

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset values (rst_n low): phase counter 0, accumulator 0, FIFO empty, out_valid 0, out_data 0, fill 0, overflow 0. Reset asserted mid-block discards the partial sum. The first sample accepted after release is phase 0.
- Sample acceptance: the block has no input backpressure. A sample is accepted on every clock edge where in_valid is 1. in_valid low leaves phase and accumulator unchanged.
- Phase counter:
  - Counts 0..DECIM-1 and advances on each accepted sample.
  - Phases 0..DECIM-2: acc <= acc + in_data (phase 0 loads in_data, ignoring the old acc).
  - Phase DECIM-1 ("dump"): sum = acc + in_data; acc <= 0; phase <= 0.
- Arithmetic:
  - Accumulator width is 16 + $clog2(DECIM) + 1 bits, so no wrap is possible.
  - r = (sum + 2^(SHIFT-1)) >> SHIFT.
  - out value = (r > 255) ? 255 : r[7:0].
- Push rules:
  - The dump result is written into the FIFO on the same edge that accepts the final sample.
  - The result is visible as out_valid/out_data in the following cycle (1-cycle latency from the last sample).
- Pop rule: a pop occurs on an edge where out_valid and out_ready are both 1.
- FIFO contents and output:
  - Registered storage with wrapping read and write pointers; entries are delivered in order.
  - out_data is the head entry when out_valid is 1, and 0 when the FIFO is empty.
  - out_valid = (fill != 0).
  - fill updates on the same edge as each push or pop.
- Full FIFO and push:
  - Without a simultaneous pop, the result is dropped, overflow <= 1, and the FIFO is unchanged.
  - With a simultaneous pop, the push is accepted and fill stays at DEPTH.
- Empty FIFO and push: out_valid rises next cycle. There is no same-cycle bypass.
- Simultaneous push and pop (FIFO not full): both take effect and fill is unchanged.
- Overflow flag:
  - clr_ovf clears overflow on the next edge.
  - If a drop and clr_ovf occur in the same cycle, the set wins and overflow stays 1.
- Handshake: out_data and out_valid are stable while out_valid is 1 and out_ready is 0.

Test Plan:
1. Basic decimation (DECIM=4, SHIFT=4, out_ready=1): inputs 10, 20, 30, 40 on consecutive cycles -> out_valid pulses once, one cycle after the 40, with out_data = (100+8)>>4 = 6.
2. Rounding and gaps: inputs 8, 0, 0, 0 with in_valid low for 3 cycles between samples -> out_data = 1 ((8+8)>>4). Inputs 7, 0, 0, 0 -> out_data = 0. No output is produced during gaps.
3. Saturation: four samples of 2550 -> out_data = 255. Four samples of 65535 -> out_data = 255, with no accumulator wrap.
4. Backpressure and overflow: out_ready=0, drive 5 blocks of 4 samples with sums 16, 32, 48, 64, 80.
   - fill reaches 4 and overflow goes to 1 on the 5th dump.
   - After raising out_ready, outputs are 1, 2, 3, 4 in order; the 5th block is lost.
   - clr_ovf then clears overflow.
5. Full with simultaneous push and pop: FIFO full, out_ready=1 on the same cycle as a dump -> overflow stays 0, fill stays 4, and the new value appears last.
6. Reset mid-operation: two samples of 100 accepted, then rst_n low for 1 cycle, then 4 samples of 16 -> out_data = 4 ((64+8)>>4). All outputs read 0 while in reset.

Source files
------------

// File: rtl/fir_decim_out.sv
// FIR output stage: accumulate-and-dump decimator with rounding,
// 8-bit saturation and a small output FIFO with sticky overflow.
module fir_decim_out #(
  parameter int DECIM = 4,
  parameter int SHIFT = 4,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic [15:0]              in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [7:0]               out_data,
  output logic [$clog2(DEPTH):0]   fill,
  output logic                     overflow,
  input  logic                     clr_ovf
);

  localparam int PW = $clog2(DECIM);
  localparam int AW = 16 + PW + 1;
  localparam int AP = $clog2(DEPTH);
  localparam int FW = AP + 1;
  localparam logic [AW:0] HALF = (AW+1)'(1) << (SHIFT - 1);
  localparam logic [PW-1:0] LAST = PW'(DECIM - 1);

  logic [PW-1:0] phase;
  logic [AW-1:0] acc;
  logic [AW-1:0] sum;
  logic [AW:0]   rnd;
  logic [7:0]    res;
  logic          dump;

  logic [7:0]    mem [DEPTH];
  logic [AP-1:0] wp;
  logic [AP-1:0] rp;
  logic [FW-1:0] cnt;
  logic          ovf;
  logic          full;
  logic          pop;
  logic          push;

  // phase 0 starts a fresh block, so the old accumulator is ignored
  always_comb begin
    dump = in_valid && (phase == LAST);
    sum  = ((phase == '0) ? '0 : acc) + AW'(in_data);
    rnd  = ({1'b0, sum} + HALF) >> SHIFT;
    res  = (rnd > (AW+1)'(255)) ? 8'hff : rnd[7:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase <= '0;
      acc   <= '0;
    end else if (in_valid) begin
      if (dump) begin
        phase <= '0;
        acc   <= '0;
      end else begin
        phase <= phase + 1'b1;
        acc   <= sum;
      end
    end
  end

  always_comb begin
    full = (cnt == FW'(DEPTH));
    pop  = (cnt != '0) && out_ready;
    push = dump && (!full || pop);
  end

  always_ff @(posedge clk) begin
    if (push) mem[wp] <= res;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
      unique case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
      // a drop in the same cycle as a clear keeps the flag set
      if (dump && full && !pop) ovf <= 1'b1;
      else if (clr_ovf)         ovf <= 1'b0;
    end
  end

  assign out_valid = (cnt != '0);
  assign out_data  = out_valid ? mem[rp] : 8'h00;
  assign fill      = cnt;
  assign overflow  = ovf;

endmodule
